// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl
// ----------------------
// Write-side controller for the core's register file. Every posedge it picks
// at most one result to write back: the ALU result when one is present,
// otherwise the oldest buffered load result. The chosen result is registered
// onto rf_write_sel / rf_data_in / rf_write_en and held for a full cycle, so
// the register file's negedge write sees stable values.
//
// A per-register scoreboard (busy) tracks destinations of issued instructions
// whose results have not yet been written back. Decode is stalled on RAW and
// WAW hazards against those registers.
//
// Load-unit handshake: a load result transfers on a posedge where
// mem_valid && mem_ready are both high. mem_ready depends only on FIFO
// occupancy (never on mem_valid), so the producer may hold mem_valid with
// stable mem_rd/mem_data until it sees mem_ready.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   issue_valid/rd/rs1/rs2    instruction in decode (issue_rd written if accepted)
//   stall                     combinational hold request to decode
//   alu_valid/rd/data         single-cycle ALU result, no backpressure
//   mem_valid/ready/rd/data   load result, valid/ready handshake into FIFO
//   rf_write_sel/data_in/en   register file write port
//   busy                      scoreboard, one bit per register, bit 0 always 0
//   fifo_count                load FIFO occupancy
module regfile_writeback_ctrl #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int MEM_FIFO_DEPTH = 4,
    localparam int RW = $clog2(NUM_REGS),
    localparam int PW = $clog2(MEM_FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [RW-1:0]       issue_rd,
    input  logic [RW-1:0]       issue_rs1,
    input  logic [RW-1:0]       issue_rs2,
    output logic                stall,
    input  logic                alu_valid,
    input  logic [RW-1:0]       alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [RW-1:0]       mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    output logic [RW-1:0]       rf_write_sel,
    output logic [XLEN-1:0]     rf_data_in,
    output logic                rf_write_en,
    output logic [NUM_REGS-1:0] busy,
    output logic [CW-1:0]       fifo_count
);

    // ------------------------------------------------------------------
    // Load FIFO
    // ------------------------------------------------------------------
    logic [RW-1:0]   fifo_rd   [MEM_FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [MEM_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            fifo_nonempty;
    logic            push;
    logic            pop;

    assign fifo_nonempty = (fifo_count != '0);
    // Full blocks a push even when a pop happens in the same cycle.
    assign mem_ready     = (fifo_count < CW'(MEM_FIFO_DEPTH));
    assign push          = mem_valid && mem_ready;
    // The FIFO head is only consumed when the ALU leaves the port free.
    assign pop           = !alu_valid && fifo_nonempty;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    // Pointers are PW bits wide, so they wrap modulo the (power-of-two) depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result selection: ALU has priority over the FIFO head
    // ------------------------------------------------------------------
    logic            sel_valid;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (fifo_nonempty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
        end
    end

    // A result for x0 is consumed but never enables the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_sel <= '0;
            rf_data_in   <= '0;
            rf_write_en  <= 1'b0;
        end else if (sel_valid) begin
            rf_write_sel <= sel_rd;
            rf_data_in   <= sel_data;
            rf_write_en  <= (sel_rd != '0);
        end else begin
            rf_write_en  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and stall
    // ------------------------------------------------------------------
    logic                issue_accept;
    logic [NUM_REGS-1:0] busy_next;

    // stall looks only at registered busy bits, so a result landing this
    // cycle releases decode on the following cycle.
    assign stall        = busy[issue_rs1] | busy[issue_rs2] | (issue_valid & busy[issue_rd]);
    assign issue_accept = issue_valid && !stall;

    // Clear is applied before set so that a same-cycle set of the same rd wins.
    always_comb begin
        busy_next = busy;
        if (sel_valid) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (issue_accept && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl: a table of per-cycle vectors with
// hand-computed expectations, followed by hand-written sequences for
// mid-operation reset and load backpressure / FIFO draining.
module tb_regfile_writeback_ctrl;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  rf_write_sel;
    logic [31:0] rf_data_in;
    logic        rf_write_en;
    logic [31:0] busy;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    regfile_writeback_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .stall        (stall),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .rf_write_sel (rf_write_sel),
        .rf_data_in   (rf_data_in),
        .rf_write_en  (rf_write_en),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  ird, rs1, rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        e_stall, e_ready;          // before the edge
        logic        e_en;                      // after the edge
        logic [4:0]  e_sel;
        logic [31:0] e_data;
        logic        chk_sd;                    // compare sel/data this row
        logic [31:0] e_busy;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] mdat, input logic e_stall, input logic e_ready,
                       input logic e_en, input logic [4:0] e_sel, input logic [31:0] e_data,
                       input logic chk_sd, input logic [31:0] e_busy, input logic [2:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.adat = adat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.e_stall = e_stall; v.e_ready = e_ready;
        v.e_en = e_en; v.e_sel = e_sel; v.e_data = e_data; v.chk_sd = chk_sd;
        v.e_busy = e_busy; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic av, input logic [4:0] ard,
                         input logic [31:0] adat, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] mdat);
        issue_valid = iv; issue_rd = ird; issue_rs1 = rs1; issue_rs2 = rs2;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic apply(input int idx, input vec_t v);
        drive(v.iv, v.ird, v.rs1, v.rs2, v.av, v.ard, v.adat, v.mv, v.mrd, v.mdat);
        #1;
        check($sformatf("v%0d.stall", idx), 32'(stall), 32'(v.e_stall));
        check($sformatf("v%0d.ready", idx), 32'(mem_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        check($sformatf("v%0d.en", idx), 32'(rf_write_en), 32'(v.e_en));
        if (v.chk_sd) begin
            check($sformatf("v%0d.sel", idx), 32'(rf_write_sel), 32'(v.e_sel));
            check($sformatf("v%0d.data", idx), rf_data_in, v.e_data);
        end
        check($sformatf("v%0d.busy", idx), busy, v.e_busy);
        check($sformatf("v%0d.cnt", idx), 32'(fifo_count), 32'(v.e_cnt));
    endtask

    // ---------------- scoreboard for backpressure sequence ----------------
    logic [36:0] exp_q[$];   // {rd, data}

    // ---------------- main test ----------------
    initial begin
        int model_cnt;
        int li;
        logic [36:0] e;
        logic [36:0] loads[5];
        logic pushed;
        logic popped;

        // ---- reset with no clock edge ----
        idle();
        rst = 1'b1;
        #3;
        check("rst0.en", 32'(rf_write_en), 0);
        check("rst0.sel", 32'(rf_write_sel), 0);
        check("rst0.data", rf_data_in, 0);
        check("rst0.busy", busy, 0);
        check("rst0.cnt", 32'(fifo_count), 0);
        check("rst0.ready", 32'(mem_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table ----
        //  iv ird rs1 rs2  av ard adat          mv mrd mdat      st rdy  en sel data     sd busy          cnt
        add(1, 5,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 0,  32'h0,        1, 32'h0000_0020, 0);
        add(0, 0,  5,  0,   1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    1, 1,   1, 5,  32'hDEADBEEF, 1, 32'h0,         0);
        add(0, 0,  5,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 5,  32'hDEADBEEF, 1, 32'h0,         0);
        add(0, 0,  0,  0,   1, 3,  32'hA3A3,     1, 7,  32'h1234, 0, 1,   1, 3,  32'hA3A3,     1, 32'h0,         1);
        add(0, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   1, 7,  32'h1234,     1, 32'h0,         0);
        add(0, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 7,  32'h1234,     1, 32'h0,         0);
        add(1, 0,  0,  0,   1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,    0, 1,   0, 0,  32'h0,        0, 32'h0,         0);
        add(0, 0,  0,  0,   0, 0,  32'h0,        1, 0,  32'h55,   0, 1,   0, 0,  32'h0,        0, 32'h0,         1);
        add(0, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 0,  32'h0,        0, 32'h0,         0);
        add(1, 9,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 0,  32'h0,        0, 32'h0000_0200, 0);
        add(1, 9,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    1, 1,   0, 0,  32'h0,        0, 32'h0000_0200, 0);
        add(1, 4,  0,  9,   0, 0,  32'h0,        0, 0,  32'h0,    1, 1,   0, 0,  32'h0,        0, 32'h0000_0200, 0);
        add(0, 0,  0,  9,   0, 0,  32'h0,        1, 9,  32'h99,   1, 1,   0, 0,  32'h0,        0, 32'h0000_0200, 1);
        add(0, 0,  0,  9,   0, 0,  32'h0,        0, 0,  32'h0,    1, 1,   1, 9,  32'h99,       1, 32'h0,         0);
        add(1, 9,  0,  9,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   0, 9,  32'h99,       1, 32'h0000_0200, 0);
        add(1, 12, 0,  0,   1, 9,  32'h909,      0, 0,  32'h0,    0, 1,   1, 9,  32'h909,      1, 32'h0000_1000, 0);
        add(1, 20, 0,  0,   1, 20, 32'h20,       0, 0,  32'h0,    0, 1,   1, 20, 32'h20,       1, 32'h0010_1000, 0);
        add(0, 0,  0,  0,   1, 12, 32'hC,        0, 0,  32'h0,    0, 1,   1, 12, 32'hC,        1, 32'h0010_0000, 0);
        add(0, 0,  0,  0,   0, 0,  32'h0,        1, 20, 32'h2020, 0, 1,   0, 12, 32'hC,        1, 32'h0010_0000, 1);
        add(0, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,    0, 1,   1, 20, 32'h2020,     1, 32'h0,         0);

        foreach (vq[i]) apply(i, vq[i]);

        // ---- reset mid-operation ----
        drive(1, 6, 0, 0, 1, 2, 32'h77, 1, 8, 32'h1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 2, 32'h77, 1, 8, 32'h2);
        @(posedge clk);
        #1;
        check("mid.pre_busy", busy, 32'h0000_0040);
        check("mid.pre_cnt", 32'(fifo_count), 2);
        check("mid.pre_en", 32'(rf_write_en), 1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("mid.en", 32'(rf_write_en), 0);
        check("mid.sel", 32'(rf_write_sel), 0);
        check("mid.data", rf_data_in, 0);
        check("mid.busy", busy, 0);
        check("mid.cnt", 32'(fifo_count), 0);
        check("mid.ready", 32'(mem_ready), 1);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid.post_en", 32'(rf_write_en), 0);
        check("mid.post_cnt", 32'(fifo_count), 0);

        // ---- backpressure: ALU busy 6 cycles, 5 loads offered ----
        for (int k = 0; k < 5; k++) loads[k] = {5'(21 + k), 32'hB000 + 32'(k)};
        model_cnt = 0;
        li = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 0, 1, 5'(c + 1), 32'hA000 + 32'(c),
                  1, loads[li][36:32], loads[li][31:0]);
            #1;
            check($sformatf("bp%0d.ready", c), 32'(mem_ready), 32'(model_cnt < 4));
            if (model_cnt < 4) begin
                exp_q.push_back(loads[li]);
                li++;
                model_cnt++;
            end
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.en", c), 32'(rf_write_en), 1);
            check($sformatf("bp%0d.sel", c), 32'(rf_write_sel), 32'(c + 1));
            check($sformatf("bp%0d.data", c), rf_data_in, 32'hA000 + 32'(c));
            check($sformatf("bp%0d.cnt", c), 32'(fifo_count), 32'(model_cnt));
        end
        check("bp.accepted", 32'(li), 4);

        // Drain: ALU idle, remaining load keeps being offered until taken.
        for (int c = 0; c < 12 && (exp_q.size() != 0 || li < 5); c++) begin
            if (li < 5) drive(0, 0, 0, 0, 0, 0, 0, 1, loads[li][36:32], loads[li][31:0]);
            else        idle();
            #1;
            check($sformatf("dr%0d.ready", c), 32'(mem_ready), 32'(model_cnt < 4));
            pushed = (li < 5) && (model_cnt < 4);
            popped = (model_cnt > 0);
            e = '0;
            if (popped) e = exp_q.pop_front();
            if (pushed) begin
                exp_q.push_back(loads[li]);
                li++;
            end
            model_cnt = model_cnt + int'(pushed) - int'(popped);
            @(posedge clk);
            #1;
            check($sformatf("dr%0d.en", c), 32'(rf_write_en), 32'(popped));
            if (popped) begin
                check($sformatf("dr%0d.sel", c), 32'(rf_write_sel), 32'(e[36:32]));
                check($sformatf("dr%0d.data", c), rf_data_in, e[31:0]);
            end
            check($sformatf("dr%0d.cnt", c), 32'(fifo_count), 32'(model_cnt));
        end
        check("dr.left", 32'(exp_q.size()), 0);
        check("dr.taken", 32'(li), 5);
        idle();
        @(posedge clk);
        #1;
        check("dr.idle_en", 32'(rf_write_en), 0);
        check("dr.idle_cnt", 32'(fifo_count), 0);
        check("dr.idle_ready", 32'(mem_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
- Write-side controller for the core's 32x32 register file (negedge write, posedge registered read).
- Arbitrates results from the ALU (single-cycle, no backpressure) and the load unit (valid/ready handshake, buffered in a small FIFO).
- Drives the register file's write select, write data and write enable.
- Keeps a per-register scoreboard so decode can stall on RAW/WAW hazards against writes still in flight.

Parameters:
XLEN, 32, data width of results and register file write port
NUM_REGS, 32, architectural registers; index width log2(NUM_REGS)=5
MEM_FIFO_DEPTH, 4, load-result FIFO entries; power of two, >=2

Ports:
clk  in  1  core clock, all state on posedge
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  decode issuing an instruction that writes issue_rd
issue_rd  in  5  destination of issued instruction
issue_rs1  in  5  source 1 of instruction in decode
issue_rs2  in  5  source 2 of instruction in decode
stall  out  1  combinational: decode must hold; issue ignored while high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  FIFO can accept (= not full)
mem_rd  in  5  load destination
mem_data  in  XLEN  load result
rf_write_sel  out  5  to register file write_sel
rf_data_in  out  XLEN  to register file data_in
rf_write_en  out  1  to register file write_en
busy  out  NUM_REGS  scoreboard bit vector, bit 0 always 0
fifo_count  out  log2(DEPTH)+1  load FIFO occupancy

Behaviour:
- Reset (async, rst high): rf_write_en=0, rf_write_sel=0, rf_data_in=0, busy=0, FIFO empty (fifo_count=0, mem_ready=1). Reset mid-operation discards FIFO contents and all pending scoreboard bits immediately.
- Write outputs registered on posedge and held one full cycle, so the register file's negedge write in that cycle is stable. A read issued on the following posedge returns the new value.
- Selection each posedge, priority ALU > FIFO head:
  - alu_valid=1: outputs load alu_rd/alu_data; FIFO not popped.
  - else FIFO non-empty: pop head into outputs.
  - else rf_write_en<=0; sel/data hold previous value.
- x0 rule:
  - Any selected result with rd=0 is consumed (FIFO popped if from FIFO) but rf_write_en<=0.
  - Loads to x0 are still enqueued.
- FIFO:
  - Push when mem_valid && mem_ready. mem_ready=1 iff fifo_count<DEPTH; combinational from count only, no dependence on mem_valid.
  - Push and pop in the same cycle allowed at any occupancy except full. When full, mem_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - fifo_count = pushes minus pops; never exceeds DEPTH or goes below 0.
- Scoreboard:
  - Issue accepted = issue_valid && !stall. On acceptance with issue_rd!=0, busy[issue_rd]<=1 at posedge.
  - busy[rd]<=0 at the posedge a result for rd is selected (same edge the outputs load).
  - Same rd set and cleared in one cycle: set wins.
- stall = busy[issue_rs1] | busy[issue_rs2] | (issue_valid & busy[issue_rd]). busy[0] is constant 0. stall depends only on current busy state, not on this cycle's results.
- Producer contract (not checked): at most one in-flight producer per rd, guaranteed by the WAW stall term.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> outputs 0, busy=0, mem_ready=1, fifo_count=0, with no clk edge needed.
- Issue rd=5 then alu_valid rd=5 data=0xDEADBEEF next cycle -> busy[5]=1 for one cycle; rf_write_en=1, sel=5, data=0xDEADBEEF; busy[5]=0 after; rs1=5 stall drops the cycle after.
- Concurrent: alu_valid rd=3 and mem_valid rd=7 data=0x1234 in the same cycle -> ALU written first, load written the next cycle; fifo_count 1 then 0.
- Backpressure: alu_valid held high 6 cycles while 5 loads are offered -> 4 accepted, mem_ready=0 at fifo_count=4. Drained in order 4 cycles after alu_valid drops; no loss, no duplicates.
- x0: issue rd=0 and alu rd=0 data=0xFFFFFFFF -> stall never asserted, busy[0]=0, rf_write_en=0.
- WAW/RAW: busy[9]=1, issue rd=9 or rs2=9 -> stall=1 and busy unchanged. Result for 9 arrives -> stall=0 the next cycle; issue then sets busy[9] again.
